// File: rtl/ram_rd_pkg.sv
// Shared types and defaults for the RAM stream reader and its skid FIFO.
// The optional RAM_RD_STRIDE_EN build adds a per-burst address stride to the top.
package ram_rd_pkg;

    localparam int RD_AW      = 10;
    localparam int RD_DW      = 128;
    localparam int RD_DEPTH   = 1024;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry fall-through FIFO: an incoming word is visible at the head in the
// same cycle it arrives when the FIFO is empty, and bypasses storage if taken.
module ram_rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int W = RD_DW + 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   count
);

    logic [W-1:0] slot [FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         store;
    logic         drop;

    assign valid = (count != 2'd0) || push;
    assign data  = (count != 2'd0) ? slot[rd_ptr] : push_data;

    // An empty FIFO hands a taken word straight through without storing it.
    assign drop  = (count != 2'd0) && ready;
    assign store = push && !((count == 2'd0) && ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) wr_ptr <= ~wr_ptr;
            if (drop)  rd_ptr <= ~rd_ptr;
            case ({store, drop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data slots carry no reset; only pointers and count define
    // which slots hold live words, so resetting the storage buys nothing.
    always_ff @(posedge clk) begin
        if (store) slot[wr_ptr] <= push_data;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!resetn)
        !(store && !drop && count == 2'(FIFO_DEPTH)));

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency RAM port B, streaming words on valid/ready.
// Define RAM_RD_STRIDE_EN to add the cmd_stride input (default stride is 1).
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int AW    = RD_AW,
    parameter int DEPTH = RD_DEPTH,
    parameter int DW    = RD_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
`ifdef RAM_RD_STRIDE_EN
    input  logic [AW-1:0] cmd_stride,
`endif
    output logic [AW-1:0] address_b,
    output logic          rden_b,
    input  logic [DW-1:0] ram_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    state_t        state;
    logic [AW:0]   remaining;
    logic [AW:0]   len_eff;
    logic [AW-1:0] stride;
    logic          inflight;
    logic          inflight_last;
    logic          credit_ok;
    logic [1:0]    fifo_count;
    logic          fifo_valid;
    logic [DW:0]   fifo_data;

    assign len_eff = (cmd_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cmd_len;

    // Words already in the FIFO plus the one read in flight must leave a free slot.
    assign credit_ok = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight);
    assign rden_b    = (state == RUN) && (remaining != '0) && credit_ok;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef RAM_RD_STRIDE_EN
    logic [AW-1:0] stride_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     stride_q <= AW'(1);
        else if (cmd_valid && cmd_ready) stride_q <= cmd_stride;
    end

    assign stride = stride_q;
`else
    assign stride = AW'(1);
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            address_b     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rden_b;
            inflight_last <= rden_b && (remaining == (AW+1)'(1));
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        address_b <= cmd_addr;
                        remaining <= len_eff;
                        if (len_eff != '0) state <= RUN;
                    end
                end
                RUN: begin
                    if (rden_b) begin
                        address_b <= address_b + stride;
                        remaining <= remaining - (AW+1)'(1);
                        if (remaining == (AW+1)'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_rd_skid_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data ({inflight_last, ram_q}),
        .ready     (out_ready),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_data  = fifo_data[DW-1:0];
    assign out_last  = fifo_valid && fifo_data[DW];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomised self-checking bench for ram_stream_reader against a burst-level model.
// Build with RAM_RD_STRIDE_EN defined to also exercise cmd_stride.
module tb_ram_stream_reader;

    localparam int AW    = 10;
    localparam int DW    = 128;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
`ifdef RAM_RD_STRIDE_EN
    logic [AW-1:0] cmd_stride;
`endif
    logic [AW-1:0] address_b;
    logic          rden_b;
    logic [DW-1:0] ram_q = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    logic [DW-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;

    // burst-level model
    bit m_active = 0;
    int m_addr, m_len, m_stride, m_issued, m_accepted;

    // traces for hand-computed checks
    int            acc_cyc, last_busy;
    int            iss_cyc [$];
    int            iss_addr[$];
    int            beat_cyc[$];
    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];

    ram_stream_reader dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
`ifdef RAM_RD_STRIDE_EN
        .cmd_stride(cmd_stride),
`endif
        .address_b (address_b),
        .rden_b    (rden_b),
        .ram_q     (ram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM wrapper model: one-cycle read latency, output holds otherwise
    always @(posedge clk) if (rden_b) ram_q <= mem[address_b];

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int addr_at(int k);
        return (m_addr + k * m_stride) % DEPTH;
    endfunction

    // compare process: every cycle, outputs vs the burst-level model
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_rden", rden_b, 0);
            check("rst_address", address_b, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_last", out_last, 0);
            check("rst_busy", busy, 0);
            m_active   = 0;
            m_issued   = 0;
            m_accepted = 0;
        end else begin
            bit exp_rden, exp_valid;
            exp_rden  = m_active && (m_issued < m_len) && (m_issued - m_accepted < 2);
            exp_valid = m_active && (m_issued > m_accepted);
            check("cmd_ready", cmd_ready, !m_active);
            check("busy", busy, m_active);
            check("rden_b", rden_b, exp_rden);
            check("out_valid", out_valid, exp_valid);
            if (exp_rden) check("address_b", address_b, addr_at(m_issued));
            if (exp_valid) begin
                check("out_data", out_data, mem[addr_at(m_accepted)]);
                check("out_last", out_last, m_accepted == m_len - 1);
            end
            if (busy) last_busy = cyc;
            if (rden_b) begin
                iss_cyc.push_back(cyc);
                iss_addr.push_back(int'(address_b));
            end
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
            end
            if (m_active) begin
                if (rden_b) m_issued++;
                if (out_valid && out_ready) m_accepted++;
                if (m_accepted >= m_len) m_active = 0;
            end else if (cmd_valid) begin
                acc_cyc    = cyc;
                m_addr     = int'(cmd_addr);
                m_len      = int'(cmd_len);
`ifdef RAM_RD_STRIDE_EN
                m_stride   = int'(cmd_stride);
`else
                m_stride   = 1;
`endif
                m_issued   = 0;
                m_accepted = 0;
                m_active   = (cmd_len != 0);
            end
        end
    end

    // downstream ready: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic clear_traces();
        iss_cyc.delete();
        iss_addr.delete();
        beat_cyc.delete();
        beat_data.delete();
        beat_last.delete();
    endtask

    task automatic send(input int addr, input int len, input int stride);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
`ifdef RAM_RD_STRIDE_EN
        cmd_stride = AW'(stride);
`else
        if (stride != 1) $display("note: stride %0d ignored in this build", stride);
`endif
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!m_active) break;
        end
        @(posedge clk);
        #1;
        check("idle_after_burst", busy, 0);
    endtask

    task automatic check_stream(input string name, input int addr, input int len, input int stride);
        check({name, "_beats"}, beat_data.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < beat_data.size()) begin
                check({name, "_data"}, beat_data[i], mem[(addr + i * stride) % DEPTH]);
                check({name, "_last"}, beat_last[i], i == len - 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, l, s;
        int exp_wrap[4];
        int exp_str[5];

        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
`ifdef RAM_RD_STRIDE_EN
        cmd_stride = AW'(1);
`endif
        #23;
        resetn = 1'b1;

        // basic burst, full throughput
        ready_mode = 0;
        clear_traces();
        send(5, 4, 1);
        wait_idle(50);
        check("t1_issues", iss_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_addr.size()) begin
                check("t1_addr", iss_addr[i], 5 + i);
                check("t1_issue_cyc", iss_cyc[i], acc_cyc + 1 + i);
            end
            if (i < beat_cyc.size()) check("t1_beat_cyc", beat_cyc[i], acc_cyc + 2 + i);
        end
        check_stream("t1", 5, 4, 1);
        check("t1_busy_end", last_busy, acc_cyc + 5);

        // address wrap
        clear_traces();
        send(1022, 4, 1);
        wait_idle(50);
        exp_wrap = '{1022, 1023, 0, 1};
        check("t2_issues", iss_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < iss_addr.size()) check("t2_addr", iss_addr[i], exp_wrap[i]);
        check_stream("t2", 1022, 4, 1);

        // random backpressure
        ready_mode = 1;
        clear_traces();
        a = $urandom_range(0, DEPTH - 1);
        send(a, 8, 1);
        wait_idle(200);
        check_stream("t3", a, 8, 1);

        // zero-length descriptor
        ready_mode = 0;
        clear_traces();
        send(77, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_reads", iss_addr.size(), 0);
        check("t4_no_beats", beat_data.size(), 0);
        check("t4_cmd_ready", cmd_ready, 1);

        // reset mid-burst with 3 of 6 beats delivered and output stalled
        ready_mode = 1;
        clear_traces();
        send(200, 6, 1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (m_accepted >= 3) break;
        end
        ready_mode = 2;
        check("t5_beats_before_reset", beat_data.size(), 3);
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_rden", rden_b, 0);
        check("t5_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        ready_mode = 0;
        clear_traces();
        send(300, 2, 1);
        wait_idle(50);
        check_stream("t5_after", 300, 2, 1);

`ifdef RAM_RD_STRIDE_EN
        // strided burst wrapping back to 0
        clear_traces();
        send(0, 5, 256);
        wait_idle(50);
        exp_str = '{0, 256, 512, 768, 0};
        check("t6_issues", iss_addr.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < iss_addr.size()) check("t6_addr", iss_addr[i], exp_str[i]);
        check_stream("t6", 0, 5, 256);
`else
        exp_str = '{0, 0, 0, 0, 0};
`endif

        // random bursts
        ready_mode = 1;
        for (int n = 0; n < 25; n++) begin
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 20);
`ifdef RAM_RD_STRIDE_EN
            s = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, DEPTH - 1);
`else
            s = 1;
`endif
            clear_traces();
            send(a, l, s);
            wait_idle(8 * l + 50);
            check_stream("rand", a, l, s);
        end

        // full-depth burst
        clear_traces();
        send(900, DEPTH, 1);
        wait_idle(8 * DEPTH);
        check_stream("full", 900, DEPTH, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
